// File: rtl/nids_alert_pkg.sv
// ---- nids_alert_pkg : default widths and alert entry layout for match_alert_logger (rev 1.0)
// ALERT_TIMESTAMP_EN widens every alert entry by a TS_W-bit cycle stamp in the MSBs.
`default_nettype none

package nids_alert_pkg;

  localparam int OFFSET_W_DEF  = 16;
  localparam int PKT_ID_W_DEF  = 8;
  localparam int DEPTH_DEF     = 8;
  localparam int MATCH_LAT_DEF = 1;
  localparam int CNT_W_DEF     = 16;
  localparam int TS_W          = 32;

`ifdef ALERT_TIMESTAMP_EN
  localparam int TS_EXTRA_W = TS_W;
`else
  localparam int TS_EXTRA_W = 0;
`endif

  // Entry layout, LSB first: offset, pkt_id, then the optional timestamp.
  typedef struct packed {
    logic [PKT_ID_W_DEF-1:0] pkt_id;
    logic [OFFSET_W_DEF-1:0] offset;
  } alert_tag_t;

  function automatic int alert_data_w(input int pkt_id_w, input int offset_w);
    return TS_EXTRA_W + pkt_id_w + offset_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/match_alert_logger_if.sv
// ---- match_alert_logger_if : valid/ready alert read port (rev 1.0)
// Optional ALERT_TIMESTAMP_EN only changes DATA_W, chosen by the instantiator.
`default_nettype none

interface match_alert_logger_if #(
  parameter int DATA_W = 24
);

  logic              alert_valid;
  logic              alert_ready;
  logic [DATA_W-1:0] alert_data;

  modport master (
    output alert_valid,
    output alert_data,
    input  alert_ready
  );

  modport slave (
    input  alert_valid,
    input  alert_data,
    output alert_ready
  );

endinterface

`default_nettype wire

// File: rtl/alert_fifo.sv
// ---- alert_fifo : synchronous FIFO with registered storage, level and full/empty (rev 1.0)
// Unaffected by ALERT_TIMESTAMP_EN apart from WIDTH.
`default_nettype none

module alert_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (do_push) mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

`default_nettype wire

// File: rtl/match_alert_logger.sv
// ---- match_alert_logger : tags ifFinal matches with {pkt_id, offset}, buffers them, keeps stats (rev 1.0)
// Define ALERT_TIMESTAMP_EN to prepend a free-running 32-bit cycle stamp to each alert.
`default_nettype none

module match_alert_logger
  import nids_alert_pkg::*;
#(
  parameter int OFFSET_W  = OFFSET_W_DEF,
  parameter int PKT_ID_W  = PKT_ID_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int MATCH_LAT = MATCH_LAT_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   byte_valid,
  input  logic                   pkt_start,
  input  logic                   if_final,
  input  logic                   clear_stats,
  match_alert_logger_if.master   alert_if,
  output logic [CNT_W-1:0]       match_count,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int TAG_W  = PKT_ID_W + OFFSET_W;
  localparam int DATA_W = alert_data_w(PKT_ID_W, OFFSET_W);

  logic [PKT_ID_W-1:0] pkt_id_q, pkt_id_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [TAG_W-1:0]    tag;
  logic                dly_valid;
  logic [TAG_W-1:0]    dly_tag;
  logic [DATA_W-1:0]   entry;
  logic                push, pop, accept, drop;
  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    match_count_q, match_count_d;
  logic [CNT_W-1:0]    drop_count_q, drop_count_d;
  logic                overflow_q, overflow_d;

  always_comb begin
    pkt_id_d = pkt_id_q;
    offset_d = offset_q;
    if (byte_valid) begin
      if (pkt_start) begin
        pkt_id_d = pkt_id_q + PKT_ID_W'(1);
        offset_d = '0;
      end else if (offset_q != '1) begin
        offset_d = offset_q + OFFSET_W'(1);
      end
    end
  end

  // The byte is tagged with the post-update counters so byte 0 carries offset 0.
  assign tag = {pkt_id_d, offset_d};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_id_q <= '0;
      offset_q <= '0;
    end else begin
      pkt_id_q <= pkt_id_d;
      offset_q <= offset_d;
    end
  end

  generate
    if (MATCH_LAT == 0) begin : g_lat0
      assign dly_valid = byte_valid;
      assign dly_tag   = tag;
    end else begin : g_pipe
      logic [MATCH_LAT-1:0] vld_q, vld_d;
      logic [TAG_W-1:0]     tag_q [MATCH_LAT];
      logic [TAG_W-1:0]     tag_d [MATCH_LAT];

      always_comb begin
        vld_d    = vld_q;
        vld_d[0] = byte_valid;
        tag_d[0] = tag;
        for (int i = 1; i < MATCH_LAT; i++) begin
          vld_d[i] = vld_q[i-1];
          tag_d[i] = tag_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_q <= '0;
          for (int i = 0; i < MATCH_LAT; i++) tag_q[i] <= '0;
        end else begin
          vld_q <= vld_d;
          for (int i = 0; i < MATCH_LAT; i++) tag_q[i] <= tag_d[i];
        end
      end

      assign dly_valid = vld_q[MATCH_LAT-1];
      assign dly_tag   = tag_q[MATCH_LAT-1];
    end
  endgenerate

`ifdef ALERT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  assign ts_d = ts_q + TS_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_d;
  end

  assign entry = {ts_q, dly_tag};
`else
  assign entry = dly_tag;
`endif

  assign push   = dly_valid & if_final;
  assign pop    = alert_if.alert_valid & alert_if.alert_ready;
  assign accept = push & (~fifo_full | pop);
  assign drop   = push & fifo_full & ~pop;

  alert_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (entry),
    .dout  (alert_if.alert_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign alert_if.alert_valid = ~fifo_empty;

  // A clear in the same cycle as a push or drop swallows that event.
  always_comb begin
    match_count_d = match_count_q;
    drop_count_d  = drop_count_q;
    overflow_d    = overflow_q;
    if (clear_stats) begin
      match_count_d = '0;
      drop_count_d  = '0;
      overflow_d    = 1'b0;
    end else begin
      if (accept && match_count_q != '1) match_count_d = match_count_q + CNT_W'(1);
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_count_q != '1) drop_count_d = drop_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_count_q <= '0;
      drop_count_q  <= '0;
      overflow_q    <= 1'b0;
    end else begin
      match_count_q <= match_count_d;
      drop_count_q  <= drop_count_d;
      overflow_q    <= overflow_d;
    end
  end

  assign match_count = match_count_q;
  assign drop_count  = drop_count_q;
  assign overflow    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_match_alert_logger.sv
// ---- tb_match_alert_logger : directed self-checking bench for match_alert_logger (rev 1.0)
// Compares only the low {pkt_id, offset} bits, so it also builds with ALERT_TIMESTAMP_EN.
`default_nettype none

module tb_match_alert_logger;
  import nids_alert_pkg::*;

  localparam int DW = alert_data_w(8, 16);

  logic        clk = 1'b0;
  logic        reset;
  logic        byte_valid;
  logic        pkt_start;
  logic        if_final;
  logic        clear_stats;
  logic [15:0] match_count;
  logic [15:0] drop_count;
  logic        overflow;
  logic [3:0]  fifo_level;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic        prev_m;
  logic [23:0] popq [$];

  match_alert_logger_if #(.DATA_W(DW)) alert_if ();

  match_alert_logger #(
    .OFFSET_W  (16),
    .PKT_ID_W  (8),
    .DEPTH     (8),
    .MATCH_LAT (1),
    .CNT_W     (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .byte_valid  (byte_valid),
    .pkt_start   (pkt_start),
    .if_final    (if_final),
    .clear_stats (clear_stats),
    .alert_if    (alert_if),
    .match_count (match_count),
    .drop_count  (drop_count),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  // Inputs only change at posedge+1, so a handshake seen at negedge is the one taken next edge.
  always @(negedge clk)
    if (!reset && alert_if.alert_valid && alert_if.alert_ready)
      popq.push_back(alert_if.alert_data[23:0]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle: present a byte and raise if_final for the byte presented one cycle earlier.
  task automatic cyc(input logic bv, input logic ps, input logic m);
    byte_valid = bv;
    pkt_start  = ps;
    if_final   = prev_m;
    prev_m     = m;
    step();
  endtask

  task automatic do_reset(input logic hold_final);
    reset                = 1'b1;
    byte_valid           = 1'b0;
    pkt_start            = 1'b0;
    if_final             = hold_final;
    clear_stats          = 1'b0;
    alert_if.alert_ready = 1'b0;
    prev_m               = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    popq.delete();
  endtask

  task automatic check_pop(input string tag, input int idx, input logic [23:0] exp);
    logic [23:0] obs;
    obs = (idx < popq.size()) ? popq[idx] : 24'hffffff;
    check(tag, obs, exp);
  endtask

  initial begin
    // Reset while if_final is held high.
    reset = 1'b1;
    do_reset(1'b1);
    repeat (3) step();
    check("rst_valid", alert_if.alert_valid, 0);
    check("rst_data", alert_if.alert_data[23:0], 0);
    check("rst_match", match_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_level", fifo_level, 0);
    if_final = 1'b0;

    // Eight-byte packet, match on byte 7.
    do_reset(1'b0);
    cyc(1, 1, 0);
    for (int i = 1; i < 7; i++) cyc(1, 0, 0);
    cyc(1, 0, 1);
    cyc(0, 0, 0);
    check("p8_valid", alert_if.alert_valid, 1);
    check("p8_data", alert_if.alert_data[23:0], {8'd1, 16'd7});
    check("p8_match", match_count, 1);
    check("p8_level", fifo_level, 1);
    alert_if.alert_ready = 1'b1;
    step();
    alert_if.alert_ready = 1'b0;
    check("p8_level_popped", fifo_level, 0);
    check_pop("p8_pop", 0, {8'd1, 16'd7});

    // Two packets drained on the fly.
    do_reset(1'b0);
    alert_if.alert_ready = 1'b1;
    for (int i = 0; i < 6; i++) cyc(1, i == 0, (i == 2) || (i == 5));
    cyc(1, 1, 1);
    cyc(1, 0, 0);
    repeat (4) cyc(0, 0, 0);
    alert_if.alert_ready = 1'b0;
    check("two_cnt", popq.size(), 3);
    check_pop("two_e0", 0, {8'd1, 16'd2});
    check_pop("two_e1", 1, {8'd1, 16'd5});
    check_pop("two_e2", 2, {8'd2, 16'd0});
    check("two_match", match_count, 3);

    // Ten matches into an eight-deep FIFO with the consumer stalled.
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) cyc(1, i == 0, 1);
    cyc(1, 0, 1);
    check("ovf_level", fifo_level, 8);
    check("ovf_drop", drop_count, 2);
    check("ovf_flag", overflow, 1);
    check("ovf_match", match_count, 8);

    // Push (offset 10) and pop in the same cycle on a full FIFO.
    alert_if.alert_ready = 1'b1;
    cyc(0, 0, 0);
    alert_if.alert_ready = 1'b0;
    check("pp_level", fifo_level, 8);
    check("pp_drop", drop_count, 2);
    check("pp_match", match_count, 9);

    clear_stats = 1'b1;
    cyc(0, 0, 0);
    clear_stats = 1'b0;
    check("clr_match", match_count, 0);
    check("clr_drop", drop_count, 0);
    check("clr_ovf", overflow, 0);
    check("clr_level", fifo_level, 8);

    alert_if.alert_ready = 1'b1;
    repeat (10) cyc(0, 0, 0);
    alert_if.alert_ready = 1'b0;
    check("drain_cnt", popq.size(), 9);
    for (int i = 0; i < 8; i++) check_pop($sformatf("drain_e%0d", i), i, {8'd1, 16'(i)});
    check_pop("drain_e8", 8, {8'd1, 16'd10});
    check("drain_level", fifo_level, 0);

    // Clear coincident with a push: entry stored, not counted.
    cyc(1, 0, 1);
    clear_stats = 1'b1;
    cyc(0, 0, 0);
    clear_stats = 1'b0;
    check("clrpush_match", match_count, 0);
    check("clrpush_level", fifo_level, 1);
    check("clrpush_data", alert_if.alert_data[23:0], {8'd1, 16'd11});

    // 70000-byte packet: offset saturates at 65535.
    do_reset(1'b0);
    cyc(1, 1, 0);
    for (int i = 1; i < 70000; i++) cyc(1, 0, i == 69999);
    cyc(0, 0, 0);
    check("sat_valid", alert_if.alert_valid, 1);
    check("sat_data", alert_if.alert_data[23:0], {8'd1, 16'hffff});
    check("sat_match", match_count, 1);
    check("sat_drop", drop_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/match_alert_logger.md
Name: match_alert_logger

Overview:
Downstream stage of top_pattern. Consumes the per-byte match flag (ifFinal) and the byte strobe that fed the matcher, and tags each match with packet ID and byte offset. Buffers the tagged alerts in a small FIFO with a valid/ready read port, for host/CPU draining. Keeps saturating match/drop statistics.

Parameters:
OFFSET_W, 16, width of byte-offset-in-packet field
PKT_ID_W, 8, width of wrapping packet-ID counter
DEPTH, 8, alert FIFO entries (power of 2, >=2)
MATCH_LAT, 1, cycles from byte presented to top_pattern until its ifFinal is valid (>=0)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
byte_valid  in  1  byte presented to top_pattern this cycle
pkt_start  in  1  qualifies byte_valid: first byte of a new packet
if_final  in  1  ifFinal from top_pattern, aligned MATCH_LAT cycles after its byte
clear_stats  in  1  synchronous clear of counters and overflow flag
alert_valid  out  1  FIFO head valid
alert_ready  in  1  consumer accepts head
alert_data  out  PKT_ID_W+OFFSET_W  {pkt_id, offset} of head entry
match_count  out  CNT_W  matches accepted into FIFO, saturating
drop_count  out  CNT_W  matches lost to full FIFO, saturating
overflow  out  1  sticky: at least one drop since reset/clear
fifo_level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async assert, sync deassert assumed upstream) clears all outputs to 0. Also clears offset and pkt_id counters, the delay pipeline and the FIFO pointers.
- Tag counter, on byte_valid & pkt_start: offset<=0, pkt_id<=pkt_id+1 (wraps). The first packet after reset gets ID 1.
- On byte_valid & !pkt_start: offset<=offset+1, saturating at all-ones.
- pkt_start without byte_valid is ignored.
- Tag of current byte is {pkt_id_next, offset_next}, i.e. the value after this cycle's update.
- Delay line: MATCH_LAT register stages carry {byte_valid, tag}. With MATCH_LAT=0 the tag is used combinationally.
- Push = delayed_valid & if_final. if_final without delayed_valid is ignored and not counted.
- FIFO: pop = alert_valid & alert_ready. alert_data is stable while alert_valid & !alert_ready.
- Latency: the push is visible on alert_valid one cycle after the if_final cycle, first-word registered.
- Full & push & !pop: entry dropped, drop_count++, overflow<=1.
- Full & push & pop: both occur, no drop.
- Empty & push & ready: no bypass; the entry appears the next cycle.
- match_count increments per accepted push. Counters saturate at all-ones.
- clear_stats zeroes match_count, drop_count and overflow; FIFO contents are untouched.
- clear_stats coincident with a push/drop: clear wins for that cycle; the event is not counted.
- Reset mid-packet or mid-drain discards all FIFO contents and in-flight delay entries.

Optional Feature:
ALERT_TIMESTAMP_EN:
- Defined: adds a free-running 32-bit cycle counter, reset to 0 and wrapping. Each entry stores {timestamp_at_push, pkt_id, offset], and alert_data widens by 32 with the timestamp in the MSBs.
- Undefined: no counter; alert_data is PKT_ID_W+OFFSET_W bits.

Decomposition:
- Package nids_alert_pkg: default widths; alert entry layout (field positions / typedef); TS_W=32 constant.
- One sub-module, alert_fifo: parameterised sync FIFO with push, pop, full, empty and level.
- Tagging, delay line and statistics stay in the top.

Test Plan:
- Reset with if_final=1 held -> alert_valid=0, all counters 0. Nothing is pushed until byte_valid is seen.
- Packet of 8 bytes (pkt_start on byte 0), MATCH_LAT=1, if_final pulse aligned to byte 7 -> one entry {pkt_id=1, offset=7}, match_count=1.
- Two packets with matches at offsets 2 and 5 of packet 1 and offset 0 of packet 2, alert_ready=1 -> entries {1,2}, {1,5}, {2,0} in order.
- alert_ready=0, 10 matches with DEPTH=8 -> fifo_level=8, drop_count=2, overflow=1. Drain yields the first 8 entries in order.
- Full FIFO, push and pop in the same cycle -> no drop; level stays 8. Then clear_stats -> counters=0, overflow=0, level=8.
- 70000 bytes in one packet (OFFSET_W=16), match on the last byte -> offset=65535 (saturated).
